// File: rtl/rr_req_arbiter_if.sv
// Request-side and memory-side handshake bundle for rr_req_arbiter.
// The arbiter takes the slave view; requesters and the memory port together form the master view.
interface rr_req_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(N_IN);

  logic [N_IN-1:0]        io_in_valid;
  logic [N_IN-1:0]        io_in_ready;
  logic [N_IN*ADDR_W-1:0] io_in_addr;
  logic                   io_out_valid;
  logic                   io_out_ready;
  logic [ADDR_W-1:0]      io_out_addr;
  logic [IDX_W-1:0]       io_out_chosen;

  modport slave (
    input  io_in_valid,
    input  io_in_addr,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_addr,
    output io_out_chosen
  );

  modport master (
    output io_in_valid,
    output io_in_addr,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_addr,
    input  io_out_chosen
  );
endinterface

// File: rtl/rr_req_arbiter.sv
// N-way address-request arbiter (fixed priority or round-robin) feeding a single
// registered output entry with full ready/valid flow control.
module rr_req_arbiter #(
  parameter int N_IN    = 4,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 1,
  localparam int IDX_W  = $clog2(N_IN)
) (
  input  logic               clock,
  input  logic               reset,
  rr_req_arbiter_if.slave    bus
);

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_IN - 1);

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [IDX_W-1:0]  out_chosen_q, out_chosen_d;
  logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic              can_load;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;
  logic [N_IN-1:0]   in_ready;

  // Result packs {found, index}; lowest set bit wins.
  function automatic logic [IDX_W:0] fixed_pick(input logic [N_IN-1:0] vld);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vld[i]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  // Search starts one past the last granted index and wraps modulo N_IN.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_IN-1:0] vld,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_IN; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_IN;
      if (vld[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    logic [IDX_W:0] pick;
    if (RR_MODE != 0) pick = rr_pick(bus.io_in_valid, rr_ptr_q);
    else              pick = fixed_pick(bus.io_in_valid);
    grant_vld = pick[IDX_W];
    grant_idx = pick[IDX_W-1:0];
  end

  // The output slot can take a new entry when empty or when it drains this cycle.
  assign can_load = !out_valid_q || bus.io_out_ready;
  assign accept   = grant_vld && can_load && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (accept && (grant_idx == IDX_W'(i))) in_ready[i] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_chosen_d = out_chosen_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_addr_d   = bus.io_in_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      out_chosen_d = grant_idx;
      if (RR_MODE != 0) rr_ptr_d = grant_idx;
    end else if (bus.io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_chosen_q <= '0;
      rr_ptr_q     <= PTR_RST;
    end else begin
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_chosen_q <= out_chosen_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.io_in_ready   = in_ready;
  assign bus.io_out_valid  = out_valid_q;
  assign bus.io_out_addr   = out_addr_q;
  assign bus.io_out_chosen = out_chosen_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: a round-robin instance driven from a vector
// table plus hand sequences, and a fixed-priority instance for the priority case.
module tb_rr_req_arbiter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  rr_req_arbiter_if #(.N_IN(4), .ADDR_W(32)) bus_rr ();
  rr_req_arbiter_if #(.N_IN(4), .ADDR_W(32)) bus_fx ();

  rr_req_arbiter #(.N_IN(4), .ADDR_W(32), .RR_MODE(1)) u_rr (
    .clock (clk),
    .reset (rst),
    .bus   (bus_rr.slave)
  );

  rr_req_arbiter #(.N_IN(4), .ADDR_W(32), .RR_MODE(0)) u_fx (
    .clock (clk),
    .reset (rst),
    .bus   (bus_fx.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  ch;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [3:0] v, input logic ordy, input logic [3:0] rdy,
                         input logic ov, input logic [1:0] ch, input logic [31:0] addr);
    vec_t e;
    e.v = v; e.ordy = ordy; e.rdy = rdy; e.ov = ov; e.ch = ch; e.addr = addr;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic drive_rr(input logic r, input logic [3:0] v, input logic ordy);
    @(posedge clk);
    #1;
    rst = r;
    bus_rr.io_in_valid  = v;
    bus_rr.io_out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic drive_fx(input logic [3:0] v, input logic ordy);
    @(posedge clk);
    #1;
    bus_fx.io_in_valid  = v;
    bus_fx.io_out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic chk_rr(input string nm, input logic [3:0] rdy, input logic ov,
                        input logic [1:0] ch, input logic [31:0] addr);
    chk({nm, ".ready"},  32'(bus_rr.io_in_ready),   32'(rdy));
    chk({nm, ".valid"},  32'(bus_rr.io_out_valid),  32'(ov));
    chk({nm, ".chosen"}, 32'(bus_rr.io_out_chosen), 32'(ch));
    chk({nm, ".addr"},   bus_rr.io_out_addr,        addr);
  endtask

  task automatic chk_fx(input string nm, input logic [3:0] rdy, input logic ov,
                        input logic [1:0] ch, input logic [31:0] addr);
    chk({nm, ".ready"},  32'(bus_fx.io_in_ready),   32'(rdy));
    chk({nm, ".valid"},  32'(bus_fx.io_out_valid),  32'(ov));
    chk({nm, ".chosen"}, 32'(bus_fx.io_out_chosen), 32'(ch));
    chk({nm, ".addr"},   bus_fx.io_out_addr,        addr);
  endtask

  initial begin
    // Idle after reset, five cycles.
    for (int i = 0; i < 5; i++) add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
    // All four valid: grants rotate 0,1,2,3,0,1.
    add_vec(4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h000);
    add_vec(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h000);
    add_vec(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h100);
    add_vec(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h200);
    add_vec(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h300);
    add_vec(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h000);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h100);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h100);
    // Wrap: grant 3, then inputs 0 and 3 valid -> 0 first, then 3.
    add_vec(4'b1000, 1'b1, 4'b1000, 1'b0, 2'd1, 32'h100);
    add_vec(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h300);
    add_vec(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd0, 32'h000);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h300);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'h300);

    rst = 1'b1;
    bus_rr.io_in_valid  = 4'b0000;
    bus_rr.io_out_ready = 1'b1;
    bus_rr.io_in_addr   = {32'h300, 32'h200, 32'h100, 32'h000};
    bus_fx.io_in_valid  = 4'b0000;
    bus_fx.io_out_ready = 1'b1;
    bus_fx.io_in_addr   = {32'h300, 32'h200, 32'h100, 32'h000};

    // Reset state; ready stays low under reset even with requests pending.
    @(posedge clk);
    drive_rr(1'b1, 4'b1111, 1'b1);
    chk_rr("reset", 4'b0000, 1'b0, 2'd0, 32'h0);
    chk_fx("reset_fx", 4'b0000, 1'b0, 2'd0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_rr(1'b0, tbl[i].v, tbl[i].ordy);
      chk_rr($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].ov, tbl[i].ch, tbl[i].addr);
    end

    // Backpressure: input 2 accepted, then output stalled three cycles.
    bus_rr.io_in_addr[2*32 +: 32] = 32'h2000;
    drive_rr(1'b0, 4'b0100, 1'b1);
    chk_rr("bp_accept", 4'b0100, 1'b0, 2'd3, 32'h300);
    for (int i = 0; i < 3; i++) begin
      drive_rr(1'b0, 4'b0010, 1'b0);
      chk_rr($sformatf("bp_stall%0d", i), 4'b0000, 1'b1, 2'd2, 32'h2000);
    end
    drive_rr(1'b0, 4'b0010, 1'b1);
    chk_rr("bp_release", 4'b0010, 1'b1, 2'd2, 32'h2000);
    drive_rr(1'b0, 4'b0000, 1'b1);
    chk_rr("bp_next", 4'b0000, 1'b1, 2'd1, 32'h100);
    drive_rr(1'b0, 4'b0000, 1'b1);
    chk_rr("bp_drain", 4'b0000, 1'b0, 2'd1, 32'h100);

    // Reset during a stall discards the entry and restores input-0-first order.
    drive_rr(1'b0, 4'b1000, 1'b1);
    chk_rr("rs_accept", 4'b1000, 1'b0, 2'd1, 32'h100);
    drive_rr(1'b0, 4'b0000, 1'b0);
    chk_rr("rs_stall", 4'b0000, 1'b1, 2'd3, 32'h300);
    drive_rr(1'b1, 4'b1010, 1'b0);
    chk_rr("rs_inreset", 4'b0000, 1'b1, 2'd3, 32'h300);
    drive_rr(1'b0, 4'b1010, 1'b0);
    chk_rr("rs_after", 4'b0010, 1'b0, 2'd0, 32'h0);
    drive_rr(1'b0, 4'b1000, 1'b1);
    chk_rr("rs_grant1", 4'b1000, 1'b1, 2'd1, 32'h100);
    drive_rr(1'b0, 4'b0000, 1'b1);
    chk_rr("rs_grant3", 4'b0000, 1'b1, 2'd3, 32'h300);

    // Fixed priority: input 1 starves input 3 while it stays valid.
    drive_fx(4'b1010, 1'b1);
    chk_fx("fx_first", 4'b0010, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive_fx(4'b1010, 1'b1);
      chk_fx($sformatf("fx_hold%0d", i), 4'b0010, 1'b1, 2'd1, 32'h100);
    end
    drive_fx(4'b1000, 1'b1);
    chk_fx("fx_in3", 4'b1000, 1'b1, 2'd1, 32'h100);
    drive_fx(4'b0000, 1'b1);
    chk_fx("fx_out3", 4'b0000, 1'b1, 2'd3, 32'h300);
    drive_fx(4'b0000, 1'b1);
    chk_fx("fx_drain", 4'b0000, 1'b0, 2'd3, 32'h300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
